// File: rtl/store_unit.sv
// store_unit: aligns sb/sh/sw stores onto a 4-lane word memory behind a ready handshake.
// Define STORE_MISALIGN_SPLIT_EN to run misaligned stores as two beats instead of dropping them.
module store_unit #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDRESS_WIDTH-1:0] addr,
   input  logic [2:0]               funct3,
   input  logic [DATA_WIDTH-1:0]    wdata,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-3:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic [3:0]               mem_be,
   input  logic                     mem_ready,
   output logic                     store_err
);
   typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_e;
   state_e                   state_q;
   logic                     mem_we_q;
   logic                     store_err_q;
   logic [ADDRESS_WIDTH-3:0] mem_addr_q;
   logic [DATA_WIDTH-1:0]    mem_wdata_q;
   logic [3:0]               mem_be_q;
   logic [1:0]               k;
   logic                     is_sb;
   logic                     legal;
   logic                     misaligned;
   logic                     go;
   logic [3:0]               mask;
   logic [3:0]               be1;
   logic [DATA_WIDTH-1:0]    data1;
   assign k          = addr[1:0];
   assign is_sb      = funct3 == 3'b000;
   assign legal      = !funct3[2] && funct3[1:0] != 2'b11;
   assign misaligned = (funct3 == 3'b001 && k == 2'd3) || (funct3 == 3'b010 && k != 2'd0);
   assign mask       = is_sb ? 4'b0001 : funct3 == 3'b001 ? 4'b0011 : 4'b1111;
   assign be1        = mask << k;
   assign data1      = is_sb ? {4{wdata[7:0]}} : wdata << {k, 3'b000};
`ifdef STORE_MISALIGN_SPLIT_EN
   logic                  split_q;
   logic [3:0]            be2_q;
   logic [DATA_WIDTH-1:0] data2_q;
   logic [3:0]            be2;
   logic [DATA_WIDTH-1:0] data2;
   // Upper half of the lane-shifted store, landing in the next word.
   assign be2   = mask >> (3'd4 - {1'b0, k});
   assign data2 = wdata >> (6'd32 - {1'b0, k, 3'b000});
   assign go    = legal;
`else
   assign go    = legal && !misaligned;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= 4'b0;
         store_err_q <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
         split_q     <= 1'b0;
         be2_q       <= 4'b0;
         data2_q     <= '0;
`endif
      end else begin
         store_err_q <= 1'b0;
         case (state_q)
            IDLE: if (req_valid) begin
               if (go) begin
                  state_q     <= BEAT1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= addr[ADDRESS_WIDTH-1:2];
                  mem_be_q    <= be1;
                  mem_wdata_q <= data1;
`ifdef STORE_MISALIGN_SPLIT_EN
                  split_q     <= misaligned;
                  be2_q       <= be2;
                  data2_q     <= data2;
`endif
               end else begin
                  store_err_q <= 1'b1;
               end
            end
            BEAT1: if (mem_ready) begin
`ifdef STORE_MISALIGN_SPLIT_EN
               if (split_q) begin
                  state_q     <= BEAT2;
                  mem_addr_q  <= mem_addr_q + {{(ADDRESS_WIDTH-3){1'b0}}, 1'b1};
                  mem_be_q    <= be2_q;
                  mem_wdata_q <= data2_q;
               end else begin
                  state_q  <= IDLE;
                  mem_we_q <= 1'b0;
                  mem_be_q <= 4'b0;
               end
`else
               state_q  <= IDLE;
               mem_we_q <= 1'b0;
               mem_be_q <= 4'b0;
`endif
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            BEAT2: if (mem_ready) begin
               state_q  <= IDLE;
               mem_we_q <= 1'b0;
               mem_be_q <= 4'b0;
            end
`endif
            default: begin
               state_q  <= IDLE;
               mem_we_q <= 1'b0;
               mem_be_q <= 4'b0;
            end
         endcase
      end
   end
   assign req_ready = state_q == IDLE;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign store_err = store_err_q;
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: random and directed stores checked against a byte-level model of the store rules.
module tb_store_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        mem_ready = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [2:0]  funct3 = '0;
   logic        req_ready, mem_we, store_err;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   int n_tests = 0;
   int n_fail = 0;
`ifdef STORE_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif
   typedef struct packed {logic [29:0] w; logic [3:0] be; logic [31:0] d;} beat_t;
   beat_t exp_q[$];
   bit    exp_err;
   always #5 clk = ~clk;
   store_unit dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .addr(addr), .funct3(funct3), .wdata(wdata), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ready(mem_ready), .store_err(store_err)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // Walk the stored bytes one at a time and drop each into its word/lane.
   task automatic model(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
      int n, k;
      beat_t b0, b1;
      n = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : (f == 3'd2) ? 4 : 0;
      k = int'(a[1:0]);
      exp_q.delete();
      exp_err = (n == 0) || (k + n > 4 && !SPLIT);
      if (exp_err) return;
      b0 = '0;
      b1 = '0;
      b0.w = a[31:2];
      b1.w = a[31:2] + 30'd1;
      for (int j = 0; j < n; j++)
         if (k + j < 4) b0.be[k+j] = 1'b1;
         else b1.be[k+j-4] = 1'b1;
      b0.d = (n == 1) ? {4{d[7:0]}} : d << (8 * k);
      b1.d = d >> (32 - 8 * k);
      exp_q.push_back(b0);
      if (k + n > 4) exp_q.push_back(b1);
   endtask
   task automatic do_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d, input int stall);
      model(a, f, d);
      chk("ready_pre", req_ready, 1);
      req_valid = 1'b1;
      addr = a;
      funct3 = f;
      wdata = d;
      mem_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      if (exp_err) begin
         chk("err_pulse", store_err, 1);
         chk("err_we", mem_we, 0);
         @(negedge clk);
         chk("err_clr", store_err, 0);
      end else begin
         foreach (exp_q[i]) begin
            for (int s = 0; s <= stall; s++) begin
               chk("we", mem_we, 1);
               chk("addr", mem_addr, exp_q[i].w);
               chk("be", mem_be, exp_q[i].be);
               chk("data", mem_wdata, exp_q[i].d);
               chk("busy", req_ready, 0);
               chk("no_err", store_err, 0);
               if (s < stall) begin
                  req_valid = 1'($urandom);
                  addr = $urandom;
                  funct3 = 3'($urandom);
                  wdata = $urandom;
               end else begin
                  req_valid = 1'b0;
                  mem_ready = 1'b1;
               end
               @(negedge clk);
               mem_ready = 1'b0;
            end
         end
      end
      chk("idle_we", mem_we, 0);
      chk("idle_be", mem_be, 0);
      chk("idle_ready", req_ready, 1);
   endtask
   initial begin
      logic [2:0] f;
      #1;
      chk("rst_we", mem_we, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_data", mem_wdata, 0);
      chk("rst_err", store_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_store(32'h0000_0103, 3'b000, 32'h1234_56AB, 0);
      do_store(32'h0000_0202, 3'b001, 32'hFFFF_BEEF, 1);
      do_store(32'h0000_0101, 3'b010, 32'hAABB_CCDD, 0);
      do_store(32'h0000_0100, 3'b010, 32'hCAFE_F00D, 3);
      do_store(32'h0000_0040, 3'b011, 32'h0BAD_0BAD, 0);
      do_store(32'hFFFF_FFFE, 3'b010, 32'h1122_3344, 1);
      do_store(32'h0000_0003, 3'b001, 32'h0000_A55A, 0);
      // Reset in the middle of a held first beat: nothing may resume.
      if (SPLIT) model(32'h0000_0003, 3'b001, 32'h0000_1234);
      else model(32'h0000_0100, 3'b010, 32'h0000_1234);
      req_valid = 1'b1;
      addr = SPLIT ? 32'h0000_0003 : 32'h0000_0100;
      funct3 = SPLIT ? 3'b001 : 3'b010;
      wdata = 32'h0000_1234;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_mid_we", mem_we, 1);
      chk("rst_mid_be", mem_be, exp_q[0].be);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_we0", mem_we, 0);
      chk("rst_mid_be0", mem_be, 0);
      chk("rst_mid_addr0", mem_addr, 0);
      chk("rst_mid_data0", mem_wdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_resume", mem_we, 0);
         chk("rst_ready", req_ready, 1);
      end
      mem_ready = 1'b0;
      repeat (300) begin
         f = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
         do_store($urandom, f, $urandom, $urandom_range(0, 2));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register/memory word width (fixed at 32; byte lanes = 4).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, meaning byte address width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  input  1  store request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port addr  input  ADDRESS_WIDTH  store byte address.
REQ-008 SHALL have port funct3  input  3  store type: 000 sb, 001 sh, 010 sw.
REQ-009 SHALL have port wdata  input  DATA_WIDTH  register rs2 value.
REQ-010 SHALL have port mem_we  output  1  memory write strobe.
REQ-011 SHALL have port mem_addr  output  ADDRESS_WIDTH-2  word address of current beat.
REQ-012 SHALL have port mem_wdata  output  DATA_WIDTH  lane-aligned write data.
REQ-013 SHALL have port mem_be  output  4  byte enables, bit i = bits [8i+7:8i].
REQ-014 SHALL have port mem_ready  input  1  memory accepts the beat this cycle.
REQ-015 SHALL have port store_err  output  1  one-cycle pulse: request dropped.

Function
REQ-016 SHALL implement FSM states IDLE, BEAT1, BEAT2; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request when req_valid && req_ready, registering addr, funct3, wdata; request inputs ignored outside IDLE.
REQ-018 SHALL, on acceptance of a legal store, enter BEAT1 next cycle with mem_we = 1; first write beat appears exactly one cycle after acceptance.
REQ-019 SHALL hold mem_we, mem_addr, mem_wdata, mem_be stable in BEAT1/BEAT2 until mem_ready = 1; beat completes on that edge.
REQ-020 SHALL, on BEAT1 completion, go to BEAT2 if store splits, else IDLE; BEAT2 completion goes to IDLE.
REQ-021 SHALL drive mem_we = 0, mem_be = 0 in IDLE.
REQ-022 SHALL, for sb at offset k = addr[1:0]: mem_be = 0001<<k, mem_wdata = wdata[7:0] replicated to all four lanes.
REQ-023 SHALL, for sh at k in {0,1,2}: mem_be = 0011<<k, mem_wdata = wdata<<(8k); single beat.
REQ-024 SHALL, for sw at k = 0: mem_be = 1111, mem_wdata = wdata; single beat.
REQ-025 SHALL treat sh at k = 3 and sw at k != 0 as misaligned (handling per Configuration).
REQ-026 SHALL, for a split store, drive BEAT1 at word addr[A-1:2], mem_be = (lower 4 bits of (mask<<k)), data = wdata<<(8k); BEAT2 at word+1 (modulo 2^(A-2), wraps to 0), mem_be = mask>>(4-k), data = wdata>>(8(4-k))), where mask = 0011 (sh) or 1111 (sw).
REQ-027 SHALL treat funct3 not in {000,001,010} as illegal: accepted, no write, store_err = 1 for the cycle after acceptance, FSM stays IDLE.
REQ-028 SHALL never assert store_err and mem_we in the same cycle.

Reset
REQ-029 SHALL, while rst_n = 0, force state IDLE, req_ready = 1 after release, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0, store_err = 0.
REQ-030 SHALL abandon any in-flight beat on reset assertion (including between BEAT1 and BEAT2 of a split); no write resumes after release.

Configuration
REQ-031 SHALL, with macro STORE_MISALIGN_SPLIT_EN defined, execute misaligned stores as two beats per REQ-026.
REQ-032 SHALL, without STORE_MISALIGN_SPLIT_EN, drop misaligned stores: no write, store_err pulse one cycle after acceptance, FSM stays IDLE, BEAT2 logic absent.

Verification
REQ-033 SHALL cover sb addr=0x103 wdata=0x123456AB, mem_ready=1 -> one beat, mem_addr=0x40, mem_be=1000, mem_wdata=0xABABABAB, back in IDLE.
REQ-034 SHALL cover sh addr=0x202 wdata=0xFFFFBEEF -> mem_addr=0x80, mem_be=1100, mem_wdata[31:16]=0xBEEF.
REQ-035 SHALL cover sw addr=0x101 wdata=0xAABBCCDD with split enabled -> beat1 word 0x40 be=1110 data[31:8]=0xBBCCDD; beat2 word 0x41 be=0001 data[7:0]=0xAA; same with split disabled -> no mem_we, store_err pulse.
REQ-036 SHALL cover mem_ready held 0 for 3 cycles during BEAT1 -> outputs stable, req_ready = 0, beat completes on 4th cycle.
REQ-037 SHALL cover funct3=011 -> no write, store_err one-cycle pulse; and rst_n low between BEAT1 and BEAT2 of sh addr=0x3 -> BEAT2 never issued, outputs zero.
REQ-038 SHALL cover sw at addr=0xFFFFFFFE with split enabled -> beat2 mem_addr wraps to 0x0.
